uart_transmitter: RTL and testbench



---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_baud_counter.sv | 64 ++++++
 rtl/uart_transmitter.sv | 182 ++++++++++++++++++
 tb/tb_uart_transmitter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART serial blocks (transmitter and receiver).
//   - uart_state_e       : frame sequencing states (2-bit encoding)
//   - DATA_BITS          : payload bits per frame
//   - FRAME_BITS         : start + payload + stop
//   - uart_counter_width : width needed for a counter that runs 0..n-1
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    // Width of a counter holding 0..n-1; never narrower than one bit so that
    // degenerate rates (n <= 1) still elaborate.
    function automatic int uart_counter_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// -----------------------------------------------------------------------------
// uart_baud_counter
// Free-running symbol-period counter. Counts 0..SymbolEdgeTime-1 while
// enabled and wraps; clear forces it back to 0 and has priority over enable.
// tick_o is high for the single cycle in which the counter sits at its last
// value with enable set, i.e. the cycle whose closing edge is the wrap.
//
// Ports:
//   clk_i    : system clock
//   rst_i    : asynchronous active-high reset
//   enable_i : advance the counter this cycle
//   clear_i  : hold the counter at 0
//   tick_o   : wrap strobe (one cycle per symbol period)
// -----------------------------------------------------------------------------
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int SymbolEdgeTime = 434,
    parameter int CounterWidth   = uart_counter_width(SymbolEdgeTime)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam logic [CounterWidth-1:0] LAST_COUNT = CounterWidth'(SymbolEdgeTime - 1);
    localparam logic [CounterWidth-1:0] ONE        = CounterWidth'(1'b1);

    logic [CounterWidth-1:0] cnt_q;
    logic [CounterWidth-1:0] cnt_d;
    logic                    at_last_s;

    // >= rather than == so a corrupted count can never run past the period.
    assign at_last_s = (cnt_q >= LAST_COUNT);
    assign tick_o    = enable_i & ~clear_i & at_last_s;

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Next count: clear, wrap at the last value, or increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            if (at_last_s) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
// 8N1 serial transmitter: one start bit (0), eight data bits LSB first, one
// stop bit (1). A byte is taken on any rising edge with DataInValid and
// DataInReady both high; the line drops to the start level on that same edge
// and the frame occupies exactly 10 symbol periods. DataInReady returns high
// on the edge that ends the stop bit, so a held-high valid gets its next byte
// one idle-high cycle later.
//
// Ports:
//   Clock       : system clock, rising-edge active
//   Reset       : asynchronous active-high reset (aborts any frame)
//   DataIn      : byte to send, sampled only on the accepting edge
//   DataInValid : producer has a byte on DataIn
//   DataInReady : registered; high only while idle
//   SOut        : registered serial line, idle high
// -----------------------------------------------------------------------------
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int ClockRate = 50_000_000,
    parameter int BaudRate  = 115_200
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] DataIn,
    input  logic       DataInValid,
    output logic       DataInReady,
    output logic       SOut
);

    localparam int SymbolEdgeTime    = ClockRate / BaudRate;
    localparam int ClockCounterWidth = uart_counter_width(SymbolEdgeTime);

    localparam logic [2:0]            LAST_DATA_BIT = 3'(DATA_BITS - 1);
    localparam logic [2:0]            BIT_ONE       = 3'd1;
    localparam logic [FRAME_BITS-1:0] SHIFT_IDLE    = {FRAME_BITS{1'b1}};

    uart_state_e           state_q;
    uart_state_e           state_d;
    logic [FRAME_BITS-1:0] shift_q;
    logic [FRAME_BITS-1:0] shift_d;
    logic [2:0]            bit_cnt_q;
    logic [2:0]            bit_cnt_d;
    logic                  sout_q;
    logic                  sout_d;
    logic                  ready_q;
    logic                  ready_d;

    logic                  accept_s;
    logic                  baud_clr_s;
    logic                  baud_en_s;
    logic                  baud_tick_s;

    assign accept_s   = DataInValid & ready_q & (state_q == IDLE);

    // The baud counter only runs inside a frame; idle pins it at 0 so every
    // frame starts on a fresh symbol period.
    assign baud_clr_s = (state_q == IDLE);
    assign baud_en_s  = ~baud_clr_s;

    uart_baud_counter #(
        .SymbolEdgeTime (SymbolEdgeTime),
        .CounterWidth   (ClockCounterWidth)
    ) u_baud (
        .clk_i    (Clock),
        .rst_i    (Reset),
        .enable_i (baud_en_s),
        .clear_i  (baud_clr_s),
        .tick_o   (baud_tick_s)
    );

    // State and datapath registers; reset lands in a clean idle frame.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            shift_q   <= SHIFT_IDLE;
            bit_cnt_q <= 3'd0;
            sout_q    <= 1'b1;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            sout_q    <= sout_d;
            ready_q   <= ready_d;
        end
    end

    // Next-state logic: each non-idle state advances on the baud wrap.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            IDLE: begin
                bit_cnt_d = 3'd0;
                if (accept_s) begin
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (baud_tick_s) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end else begin
                    state_d   = START;
                end
            end
            DATA: begin
                if (baud_tick_s) begin
                    if (bit_cnt_q == LAST_DATA_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                if (baud_tick_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = 3'd0;
            end
        endcase
    end

    // Output/datapath logic. The shift register holds the frame with the bit
    // currently on the line at [0]; on each wrap the next bit ([1]) is
    // registered onto SOut, so the line only moves at symbol boundaries.
    always_comb begin
        shift_d = shift_q;
        sout_d  = sout_q;
        ready_d = (state_d == IDLE);
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    shift_d = {1'b1, DataIn, 1'b0};
                    sout_d  = 1'b0;
                end else begin
                    shift_d = SHIFT_IDLE;
                    sout_d  = 1'b1;
                end
            end
            START, DATA: begin
                if (baud_tick_s) begin
                    // Ones shifted in from the top make the stop bit fall out naturally.
                    shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
                    sout_d  = shift_q[1];
                end else begin
                    shift_d = shift_q;
                    sout_d  = sout_q;
                end
            end
            STOP: begin
                sout_d = 1'b1;
                if (baud_tick_s) begin
                    shift_d = SHIFT_IDLE;
                end else begin
                    shift_d = shift_q;
                end
            end
            default: begin
                shift_d = SHIFT_IDLE;
                sout_d  = 1'b1;
                ready_d = 1'b1;
            end
        endcase
    end

    assign DataInReady = ready_q;
    assign SOut        = sout_q;

endmodule

// File: tb/tb_uart_transmitter.sv
`timescale 1ns/1ps
module tb_uart_transmitter;

    localparam int CLK_RATE  = 1000;
    localparam int BAUD      = 100;
    localparam int SET       = CLK_RATE / BAUD;
    localparam int FRAME_CYC = 10 * SET;
    localparam int TAIL      = 30;
    localparam int NVEC      = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       valid;
    logic       ready;
    logic       sout;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_transmitter #(
        .ClockRate (CLK_RATE),
        .BaudRate  (BAUD)
    ) dut (
        .Clock       (clk),
        .Reset       (rst),
        .DataIn      (din),
        .DataInValid (valid),
        .DataInReady (ready),
        .SOut        (sout)
    );

    typedef struct {
        logic [7:0] data;
        int         intr_k;
        logic [7:0] intr_d;
        logic [9:0] exp_bits;
        int         exp_ready_low;
    } vec_t;

    vec_t       vecs[NVEC];
    logic [9:0] bits;
    int         rl, we, ef;
    logic [7:0] order[256];
    logic       line[0:259];
    int         falls[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Line level k cycles after the accepting edge: 10 symbols of SET cycles.
    function automatic logic model_line(input logic [7:0] d, input int k);
        int sym;
        if (k < 0 || k >= FRAME_CYC) return 1'b1;
        sym = k / SET;
        if (sym == 0) return 1'b0;
        if (sym == 9) return 1'b1;
        return d[sym-1];
    endfunction

    // Called at a negedge; waits (bounded) for DataInReady.
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ready_wait"}, 32'(n < 300), 32'd1);
    endtask

    // Sends one byte with a single-cycle valid, then watches 130 cycles.
    // bits[i] = line sampled mid-symbol i; optional intrusion pulse at cycle intr_k.
    task automatic run_frame(input logic [7:0] d, input int intr_k, input logic [7:0] intr_d,
                             output logic [9:0] b, output int ready_low,
                             output int wave_err, output int extra_falls);
        logic prev;
        b = '0; ready_low = 0; wave_err = 0; extra_falls = 0;
        din = d; valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        din = 8'($urandom);
        prev = 1'b1;
        for (int k = 0; k < FRAME_CYC + TAIL; k++) begin
            @(negedge clk);
            if (sout !== model_line(d, k)) wave_err++;
            if (ready !== 1'b1) ready_low++;
            if (k % SET == SET / 2) b[k / SET] = sout;
            if (k > FRAME_CYC && prev === 1'b1 && sout === 1'b0) extra_falls++;
            prev = sout;
            if (k == intr_k) begin
                valid = 1'b1;
                din = intr_d;
            end else if (k == intr_k + 1) begin
                valid = 1'b0;
            end
        end
    endtask

    initial begin
        int errs, trans, gap, j;
        logic prev, tmp;

        vecs[0] = '{8'hA5, -1, 8'h00, 10'b1101001010, 100};
        vecs[1] = '{8'h3C, 35, 8'h81, 10'b1001111000, 100};
        vecs[2] = '{8'h00, -1, 8'h00, 10'b1000000000, 100};
        vecs[3] = '{8'hFF, -1, 8'h00, 10'b1111111110, 100};
        vecs[4] = '{8'h12, -1, 8'h00, 10'b1000100100, 100};
        vecs[5] = '{8'h81, 12, 8'h7E, 10'b1100000010, 100};

        // Reset and quiet idle
        rst = 1'b1; valid = 1'b0; din = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_sout", 32'(sout), 32'd1);
        check("reset_ready", 32'(ready), 32'd1);
        rst = 1'b0;
        errs = 0; trans = 0; prev = sout;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (sout !== 1'b1 || ready !== 1'b1) errs++;
            if (sout !== prev) trans++;
            prev = sout;
        end
        check("idle_level_errs", 32'(errs), 32'd0);
        check("idle_transitions", 32'(trans), 32'd0);

        // Table-driven single frames (row 1 and 5 carry an ignored busy pulse)
        for (int i = 0; i < NVEC; i++) begin
            wait_ready($sformatf("vec%0d", i));
            run_frame(vecs[i].data, vecs[i].intr_k, vecs[i].intr_d, bits, rl, we, ef);
            check($sformatf("vec%0d_bits", i), {22'd0, bits}, {22'd0, vecs[i].exp_bits});
            check($sformatf("vec%0d_ready_low", i), 32'(rl), 32'(vecs[i].exp_ready_low));
            check($sformatf("vec%0d_wave_err", i), 32'(we), 32'd0);
            check($sformatf("vec%0d_extra_frames", i), 32'(ef), 32'd0);
        end

        // Back-to-back: valid held high, 0x00 then 0xFF
        wait_ready("b2b");
        din = 8'h00; valid = 1'b1;
        falls.delete();
        prev = 1'b1;
        for (int c = 0; c < 260; c++) begin
            @(negedge clk);
            if (c == 0) din = 8'hFF;
            line[c] = sout;
            if (prev === 1'b1 && sout === 1'b0) begin
                falls.push_back(c);
                if (falls.size() == 2) valid = 1'b0;
            end
            prev = sout;
        end
        valid = 1'b0;
        check("b2b_frame_count", 32'(falls.size()), 32'd2);
        if (falls.size() >= 2) begin
            check("b2b_start_spacing", 32'(falls[1] - falls[0]), 32'd101);
            errs = 0;
            for (int i = 1; i <= 8; i++) begin
                if (line[falls[0] + SET/2 + SET*i] !== 1'b0) errs++;
                if (line[falls[1] + SET/2 + SET*i] !== 1'b1) errs++;
            end
            check("b2b_data_bits", 32'(errs), 32'd0);
            check("b2b_stop_bit", 32'(line[falls[1] + SET/2 + SET*9]), 32'd1);
            check("b2b_gap_idle", 32'(line[falls[1] - 1]), 32'd1);
        end

        // Reset in the middle of a 0x55 frame
        wait_ready("rst_mid");
        din = 8'h55; valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        for (int k = 0; k <= 47; k++) @(negedge clk);
        check("rst_mid_pre_sout", 32'(sout), 32'(model_line(8'h55, 47)));
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_async_sout", 32'(sout), 32'd1);
        check("rst_mid_async_ready", 32'(ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        errs = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (sout !== 1'b1 || ready !== 1'b1) errs++;
        end
        check("rst_mid_no_resume", 32'(errs), 32'd0);
        run_frame(8'h12, -1, 8'h00, bits, rl, we, ef);
        check("rst_after_bits", {22'd0, bits}, {22'd0, 10'b1000100100});
        check("rst_after_wave_err", 32'(we), 32'd0);

        // Randomised sweep of every byte value in shuffled order
        for (int i = 0; i < 256; i++) order[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = 1'b0;
            {order[i], order[j]} = {order[j], order[i]};
        end
        for (int i = 0; i < 256; i++) begin
            wait_ready("sweep");
            gap = int'($urandom_range(3, 0));
            repeat (gap) @(negedge clk);
            run_frame(order[i], -1, 8'h00, bits, rl, we, ef);
            check($sformatf("sweep_%02h_decode", order[i]), {24'd0, bits[8:1]}, {24'd0, order[i]});
            check($sformatf("sweep_%02h_start", order[i]), 32'(bits[0]), 32'd0);
            check($sformatf("sweep_%02h_stop", order[i]), 32'(bits[9]), 32'd1);
            check($sformatf("sweep_%02h_wave", order[i]), 32'(we + ef), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
